// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Bit-serial adder/subtractor. A single full-adder slice is reused for WIDTH
// clock cycles, working LSB first. Operands are loaded with a start/busy/done
// handshake and the finished result is presented in parallel.
//
// Ports:
//   clk    - system clock; all state updates on its rising edge
//   rst_n  - synchronous reset, active-low
//   start  - operation request, sampled only while idle
//   sel    - 0 = A+B, 1 = A-B (two's complement), captured with start
//   A, B   - operands, captured with start
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse when S/cout/ovf have been updated
//   S      - result register (sum modulo 2^WIDTH)
//   cout   - carry out of the MSB (subtract: 1 = no borrow)
//   ovf    - signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_out;
  logic             load;
  logic             last;

  // The one shared full-adder slice.
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_out = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last      = (cnt == LAST);
  assign busy      = (state == RUN);

  // Next-state logic; start is only honoured while idle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. Subtraction inverts B at load and seeds the carry with 1.
  // On the final bit, 'carry' still holds the carry into the MSB slice, so
  // the overflow flag is formed from it before it is overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_sh  <= A;
        b_sh  <= B ^ {WIDTH{sel}};
        carry <= sel;
        cnt   <= '0;
        psum  <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= carry_out;
        cnt   <= cnt + 1'b1;
        psum  <= {sum_bit, psum[WIDTH-1:1]};
        if (last) begin
          S    <= {sum_bit, psum[WIDTH-1:1]};
          cout <= carry_out;
          ovf  <= carry ^ carry_out;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
